// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: default widths, transfer direction codes and
// the bulk-transfer engine state encoding.
package chip8_pkg;

    localparam int unsigned CHIP8_DATA_W = 8;
    localparam int unsigned CHIP8_ADDR_W = 12;

    localparam logic XFER_DIR_STORE = 1'b0;
    localparam logic XFER_DIR_LOAD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STORE    = 3'd1,
        ST_LD_ISSUE = 3'd2,
        ST_LD_DRAIN = 3'd3,
        ST_FINISH   = 3'd4
    } xfer_state_t;

endpackage

// File: rtl/xfer_lat_pipe.sv
// Fixed-depth valid/index shift register that follows outstanding RAM reads
// so each returning data word can be matched to its destination index.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   i_flush     drop everything in flight (wins over i_vld)
//   i_vld/i_idx read issued this cycle and its destination index
//   o_vld/o_idx entry leaving the pipe, LAT cycles after entry
module xfer_lat_pipe #(
    parameter int unsigned LAT   = 1,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_vld,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_vld,
    output logic [IDX_W-1:0] o_idx
);

    logic             r_vld [LAT];
    logic [IDX_W-1:0] r_idx [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                r_vld[i] <= 1'b0;
                r_idx[i] <= '0;
            end
        end else if (i_flush) begin
            for (int i = 0; i < LAT; i++) begin
                r_vld[i] <= 1'b0;
            end
        end else begin
            r_vld[0] <= i_vld;
            r_idx[0] <= i_idx;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_idx[i] <= r_idx[i-1];
            end
        end
    end

    assign o_vld = r_vld[LAT-1];
    assign o_idx = r_idx[LAT-1];

endmodule

// File: rtl/cpu_reg_mem_xfer.sv
// Bulk register-file <-> program-RAM transfer engine (Fx55 / Fx65 family).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start, dir, last_reg, base_addr transfer request (latched in IDLE)
//   quirk_inc_i                     report updated I at completion
//   abort                           terminate any transfer in progress
//   busy, done, i_wr, i_new         status and I-register update
//   rd_idx / rd_data                register file read (combinational reply)
//   wr_en, wr_idx, wr_data          register file write
//   ram_en, ram_wr, ram_addr,
//   ram_in, ram_out                 program RAM port (RAM_LAT read latency)
module cpu_reg_mem_xfer
    import chip8_pkg::*;
#(
    parameter int unsigned DATA_W  = CHIP8_DATA_W,
    parameter int unsigned ADDR_W  = CHIP8_ADDR_W,
    parameter int unsigned NREGS   = 16,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     dir,
    input  logic [$clog2(NREGS)-1:0] last_reg,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic                     quirk_inc_i,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     i_wr,
    output logic [ADDR_W-1:0]        i_new,
    output logic [$clog2(NREGS)-1:0] rd_idx,
    input  logic [DATA_W-1:0]        rd_data,
    output logic                     wr_en,
    output logic [$clog2(NREGS)-1:0] wr_idx,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     ram_en,
    output logic                     ram_wr,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_in,
    input  logic [DATA_W-1:0]        ram_out
);

    localparam int unsigned IDX_W = $clog2(NREGS);

    xfer_state_t       r_state;
    logic [IDX_W-1:0]  r_last;
    logic [ADDR_W-1:0] r_base;
    logic              r_quirk;
    logic [IDX_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_ld_idx;

    logic              r_busy, r_done, r_i_wr;
    logic [ADDR_W-1:0] r_i_new;
    logic [IDX_W-1:0]  r_rd_idx;
    logic              r_wr_en;
    logic [IDX_W-1:0]  r_wr_idx;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_ram_en, r_ram_wr;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_in;

    logic              w_pipe_vld;
    logic [IDX_W-1:0]  w_pipe_idx;

    // A read enters the tracker while its address is on the RAM port, so the
    // tag emerges exactly in the cycle ram_out carries that word.
    xfer_lat_pipe #(
        .LAT   (RAM_LAT),
        .IDX_W (IDX_W)
    ) u_lat_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (abort),
        .i_vld   (r_ram_en & ~r_ram_wr),
        .i_idx   (r_ld_idx),
        .o_vld   (w_pipe_vld),
        .o_idx   (w_pipe_idx)
    );

    // Transfer sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_last     <= '0;
            r_base     <= '0;
            r_quirk    <= 1'b0;
            r_cnt      <= '0;
            r_ld_idx   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_i_wr     <= 1'b0;
            r_i_new    <= '0;
            r_rd_idx   <= '0;
            r_wr_en    <= 1'b0;
            r_wr_idx   <= '0;
            r_wr_data  <= '0;
            r_ram_en   <= 1'b0;
            r_ram_wr   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_in   <= '0;
        end else begin
            r_done  <= 1'b0;
            r_i_wr  <= 1'b0;
            r_wr_en <= w_pipe_vld;
            if (w_pipe_vld) begin
                r_wr_idx  <= w_pipe_idx;
                r_wr_data <= ram_out;
            end

            if (abort) begin
                // Anything already written stays; in-flight reads are dropped.
                r_state  <= ST_IDLE;
                r_busy   <= 1'b0;
                r_ram_en <= 1'b0;
                r_ram_wr <= 1'b0;
                r_wr_en  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_ram_en <= 1'b0;
                        r_ram_wr <= 1'b0;
                        r_busy   <= 1'b0;
                        // busy is still high during the done cycle; ignore start then.
                        if (start && !r_busy) begin
                            r_busy  <= 1'b1;
                            r_last  <= last_reg;
                            r_base  <= base_addr;
                            r_quirk <= quirk_inc_i;
                            r_i_new <= base_addr + ADDR_W'(last_reg) + ADDR_W'(1);
                            if (dir == XFER_DIR_STORE) begin
                                r_state  <= ST_STORE;
                                r_cnt    <= '0;
                                r_rd_idx <= '0;
                            end else begin
                                // Address 0 goes out immediately to keep the read pipe full.
                                r_ram_en   <= 1'b1;
                                r_ram_addr <= base_addr;
                                r_ld_idx   <= '0;
                                r_cnt      <= IDX_W'(1);
                                r_state    <= (last_reg == '0) ? ST_LD_DRAIN : ST_LD_ISSUE;
                            end
                        end
                    end

                    ST_STORE: begin
                        r_ram_en   <= 1'b1;
                        r_ram_wr   <= 1'b1;
                        r_ram_addr <= r_base + ADDR_W'(r_cnt);
                        r_ram_in   <= rd_data;
                        if (r_cnt == r_last) begin
                            r_state <= ST_FINISH;
                        end else begin
                            r_cnt    <= r_cnt + IDX_W'(1);
                            r_rd_idx <= r_cnt + IDX_W'(1);
                        end
                    end

                    ST_LD_ISSUE: begin
                        r_ram_en   <= 1'b1;
                        r_ram_wr   <= 1'b0;
                        r_ram_addr <= r_base + ADDR_W'(r_cnt);
                        r_ld_idx   <= r_cnt;
                        if (r_cnt == r_last) begin
                            r_state <= ST_LD_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + IDX_W'(1);
                        end
                    end

                    ST_LD_DRAIN: begin
                        r_ram_en <= 1'b0;
                        // Indices return in issue order, so the last one ends the drain.
                        if (w_pipe_vld && (w_pipe_idx == r_last)) begin
                            r_state <= ST_FINISH;
                        end
                    end

                    ST_FINISH: begin
                        r_ram_en <= 1'b0;
                        r_ram_wr <= 1'b0;
                        r_done   <= 1'b1;
                        r_i_wr   <= r_quirk;
                        r_state  <= ST_IDLE;
                    end

                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign i_wr     = r_i_wr;
    assign i_new    = r_i_new;
    assign rd_idx   = r_rd_idx;
    assign wr_en    = r_wr_en;
    assign wr_idx   = r_wr_idx;
    assign wr_data  = r_wr_data;
    assign ram_en   = r_ram_en;
    assign ram_wr   = r_ram_wr;
    assign ram_addr = r_ram_addr;
    assign ram_in   = r_ram_in;

endmodule

// File: tb/tb_cpu_reg_mem_xfer.sv
// Bench for cpu_reg_mem_xfer: register file and RAM environment plus an
// array-level model of what each transfer must leave behind.
module tb_cpu_reg_mem_xfer;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 12;
    localparam int unsigned NR  = 16;
    localparam int unsigned LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, dir = 1'b0, quirk_inc_i = 1'b0, abort = 1'b0;
    logic [3:0]    last_reg = '0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, done, i_wr, wr_en, ram_en, ram_wr;
    logic [AW-1:0] i_new, ram_addr;
    logic [3:0]    rd_idx, wr_idx;
    logic [DW-1:0] rd_data, wr_data, ram_in;
    logic [DW-1:0] ram_out = '0;
    logic [DW-1:0] rd_p1 = '0;

    logic [DW-1:0] mem      [4096];
    logic [DW-1:0] regs     [16];
    logic [DW-1:0] init_mem [4096];
    logic [DW-1:0] init_regs[16];
    logic [DW-1:0] exp_mem  [4096];
    logic [DW-1:0] exp_regs [16];
    logic          tb_load = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int            done_cyc;
        int            wr_cnt;
        int            first_wr;
        int            last_wr;
        int            ramw_cnt;
        int            overlap;
        int            bad_idx;
        int            i_wr_cnt;
        int            i_wr_off;
        logic [AW-1:0] inew;
        logic          busy_after;
        logic          act_after_abort;
    } res_t;

    cpu_reg_mem_xfer #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NREGS  (NR),
        .RAM_LAT(LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dir        (dir),
        .last_reg   (last_reg),
        .base_addr  (base_addr),
        .quirk_inc_i(quirk_inc_i),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .i_wr       (i_wr),
        .i_new      (i_new),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .ram_en     (ram_en),
        .ram_wr     (ram_wr),
        .ram_addr   (ram_addr),
        .ram_in     (ram_in),
        .ram_out    (ram_out)
    );

    always #5 clk = ~clk;

    assign rd_data = regs[rd_idx];

    // Register file and a RAM whose read data appears LAT=2 cycles after the address.
    always @(posedge clk) begin
        if (tb_load) begin
            mem  <= init_mem;
            regs <= init_regs;
        end else begin
            if (wr_en) regs[wr_idx] <= wr_data;
            if (ram_en && ram_wr) mem[ram_addr] <= ram_in;
        end
        rd_p1   <= mem[ram_addr];
        ram_out <= rd_p1;
    end

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== exp_mem[i]) n++;
        return n;
    endfunction

    function automatic int reg_diff();
        int n = 0;
        for (int i = 0; i < 16; i++) if (regs[i] !== exp_regs[i]) n++;
        return n;
    endfunction

    task automatic sync_env();
        init_mem  = exp_mem;
        init_regs = exp_regs;
        @(negedge clk); tb_load = 1'b1;
        @(negedge clk); tb_load = 1'b0;
    endtask

    // Apply the first 'count' element moves of a transfer to the model.
    task automatic model_xfer(input logic d, input int last, input logic [AW-1:0] base, input int count);
        logic [AW-1:0] a;
        for (int k = 0; k <= last; k++) begin
            if (k < count) begin
                a = base + AW'(k);
                if (d) exp_regs[k] = exp_mem[a];
                else   exp_mem[a]  = exp_regs[k];
            end
        end
    endtask

    // Issue one request and observe the port cycle by cycle (cycle 0 = after start).
    task automatic do_xfer(input logic d, input int last, input logic [AW-1:0] base, input logic q,
                           input int abort_at, input int restart_at, output res_t r);
        int bound;
        bound = last + 1 + LAT + 6;
        r.done_cyc = -1; r.wr_cnt = 0; r.first_wr = -1; r.last_wr = -1;
        r.ramw_cnt = 0; r.overlap = 0; r.bad_idx = 0; r.i_wr_cnt = 0; r.i_wr_off = 0;
        r.inew = '0; r.busy_after = 1'b1; r.act_after_abort = 1'b0;
        @(negedge clk);
        start = 1'b1; abort = 1'b0; dir = d; last_reg = 4'(last); base_addr = base; quirk_inc_i = q;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (wr_en) begin
                if (wr_idx != 4'(r.wr_cnt) || int'(wr_idx) > last) r.bad_idx++;
                if (r.first_wr < 0) r.first_wr = c;
                r.last_wr = c;
                r.wr_cnt++;
            end
            if (ram_en && ram_wr) r.ramw_cnt++;
            if (wr_en && ram_wr) r.overlap++;
            if (i_wr) begin
                r.i_wr_cnt++;
                if (!done) r.i_wr_off++;
            end
            if (done && r.done_cyc < 0) begin
                r.done_cyc = c;
                r.inew = i_new;
            end
            if (c == abort_at + 1) r.act_after_abort = ram_en | wr_en | done | i_wr;
            // Request inputs are scrambled after start to prove they were latched.
            start       = (c == restart_at);
            dir         = 1'($urandom);
            last_reg    = 4'($urandom);
            base_addr   = AW'($urandom);
            quirk_inc_i = 1'($urandom);
            abort       = (c == abort_at);
            if (r.done_cyc >= 0 && c == r.done_cyc + 1) begin
                r.busy_after = busy;
                start = 1'b0; abort = 1'b0;
                break;
            end
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, i_wr, wr_en, ram_en, ram_wr} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl got %b want 000000", {busy, done, i_wr, wr_en, ram_en, ram_wr});
        end
        n_checks++;
        if ({i_new, rd_idx, wr_idx, wr_data, ram_addr, ram_in} !== 48'h0) begin
            n_errors++;
            $display("FAIL reset_data got %h want 0", {i_new, rd_idx, wr_idx, wr_data, ram_addr, ram_in});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_store();
        res_t r;
        exp_regs[0] = 8'h11; exp_regs[1] = 8'h22; exp_regs[2] = 8'h33; exp_regs[3] = 8'h44;
        exp_mem[12'h304] = 8'hA5;
        sync_env();
        do_xfer(1'b0, 3, 12'h300, 1'b0, -1, -1, r);
        model_xfer(1'b0, 3, 12'h300, 4);
        n_checks++;
        if (mem_diff() != 0) begin n_errors++; $display("FAIL store_mem got %0d bad bytes want 0", mem_diff()); end
        n_checks++;
        if (mem[12'h304] !== 8'hA5) begin n_errors++; $display("FAIL store_304 got %h want a5", mem[12'h304]); end
        n_checks++;
        if (r.done_cyc + 1 != 6) begin n_errors++; $display("FAIL store_latency got %0d want 6", r.done_cyc + 1); end
        n_checks++;
        if (r.busy_after !== 1'b0) begin n_errors++; $display("FAIL store_busy_after got %b want 0", r.busy_after); end
        n_checks++;
        if (r.ramw_cnt != 4 || r.wr_cnt != 0) begin
            n_errors++; $display("FAIL store_counts got ramw=%0d wr=%0d want 4 0", r.ramw_cnt, r.wr_cnt);
        end
        n_checks++;
        if (r.i_wr_cnt != 0) begin n_errors++; $display("FAIL store_no_iwr got %0d want 0", r.i_wr_cnt); end
    endtask

    task automatic test_load();
        res_t r;
        for (int k = 0; k < 16; k++) exp_mem[12'h400 + k] = 8'(k);
        sync_env();
        do_xfer(1'b1, 15, 12'h400, 1'b0, -1, -1, r);
        for (int k = 0; k < 16; k++) exp_regs[k] = 8'(k);
        n_checks++;
        if (reg_diff() != 0) begin n_errors++; $display("FAIL load_regs got %0d bad regs want 0", reg_diff()); end
        n_checks++;
        if (r.wr_cnt != 16 || r.last_wr - r.first_wr + 1 != 16) begin
            n_errors++; $display("FAIL load_consecutive got cnt=%0d span=%0d want 16 16", r.wr_cnt, r.last_wr - r.first_wr + 1);
        end
        n_checks++;
        if (r.first_wr != LAT + 1) begin n_errors++; $display("FAIL load_first_wr got %0d want %0d", r.first_wr, LAT + 1); end
        n_checks++;
        if (r.done_cyc + 1 != 20) begin n_errors++; $display("FAIL load_latency got %0d want 20", r.done_cyc + 1); end
        n_checks++;
        if (r.bad_idx != 0 || r.ramw_cnt != 0) begin
            n_errors++; $display("FAIL load_idx got bad=%0d ramw=%0d want 0 0", r.bad_idx, r.ramw_cnt);
        end
    endtask

    task automatic test_wrap();
        res_t r;
        for (int k = 0; k < 3; k++) exp_regs[k] = 8'($urandom);
        sync_env();
        do_xfer(1'b0, 2, 12'hFFE, 1'b1, -1, -1, r);
        model_xfer(1'b0, 2, 12'hFFE, 3);
        n_checks++;
        if (mem[12'hFFE] !== exp_regs[0] || mem[12'hFFF] !== exp_regs[1] || mem[12'h000] !== exp_regs[2]) begin
            n_errors++;
            $display("FAIL wrap_mem got %h %h %h want %h %h %h", mem[12'hFFE], mem[12'hFFF], mem[12'h000],
                     exp_regs[0], exp_regs[1], exp_regs[2]);
        end
        n_checks++;
        if (mem_diff() != 0) begin n_errors++; $display("FAIL wrap_mem_all got %0d bad want 0", mem_diff()); end
        n_checks++;
        if (r.i_wr_cnt != 1 || r.i_wr_off != 0) begin
            n_errors++; $display("FAIL wrap_iwr got cnt=%0d off=%0d want 1 0", r.i_wr_cnt, r.i_wr_off);
        end
        n_checks++;
        if (r.inew !== 12'h001) begin n_errors++; $display("FAIL wrap_inew got %h want 001", r.inew); end
        n_checks++;
        if (r.done_cyc + 1 != 5) begin n_errors++; $display("FAIL wrap_latency got %0d want 5", r.done_cyc + 1); end
    endtask

    task automatic test_random();
        res_t r;
        logic d, q;
        int last, lat_exp;
        logic [AW-1:0] base, inew_exp;
        for (int it = 0; it < 16; it++) begin
            d = 1'($urandom); q = 1'($urandom);
            last = int'($urandom_range(0, 15));
            base = AW'($urandom);
            do_xfer(d, last, base, q, -1, -1, r);
            model_xfer(d, last, base, last + 1);
            lat_exp  = d ? (last + 1 + LAT + 2) : (last + 1 + 2);
            inew_exp = base + AW'(last + 1);
            n_checks++;
            if (mem_diff() != 0 || reg_diff() != 0) begin
                n_errors++; $display("FAIL rand_state it=%0d got mem=%0d regs=%0d bad want 0", it, mem_diff(), reg_diff());
            end
            n_checks++;
            if (r.done_cyc + 1 != lat_exp) begin
                n_errors++; $display("FAIL rand_latency it=%0d got %0d want %0d", it, r.done_cyc + 1, lat_exp);
            end
            n_checks++;
            if (r.i_wr_cnt != int'(q) || r.i_wr_off != 0) begin
                n_errors++; $display("FAIL rand_iwr it=%0d got %0d want %0d", it, r.i_wr_cnt, int'(q));
            end
            n_checks++;
            if (r.inew !== inew_exp) begin n_errors++; $display("FAIL rand_inew it=%0d got %h want %h", it, r.inew, inew_exp); end
            n_checks++;
            if (r.overlap != 0 || r.bad_idx != 0) begin
                n_errors++; $display("FAIL rand_strobes it=%0d got overlap=%0d badidx=%0d want 0 0", it, r.overlap, r.bad_idx);
            end
            n_checks++;
            if (r.wr_cnt != (d ? last + 1 : 0) || r.ramw_cnt != (d ? 0 : last + 1)) begin
                n_errors++; $display("FAIL rand_counts it=%0d got wr=%0d ramw=%0d", it, r.wr_cnt, r.ramw_cnt);
            end
        end
    endtask

    task automatic test_abort();
        res_t r;
        logic d;
        int last, a, cnt;
        logic [AW-1:0] base;
        // Directed: abort while the third load address is on the bus.
        for (int k = 0; k < 16; k++) exp_regs[k] = 8'($urandom);
        sync_env();
        base = AW'($urandom);
        do_xfer(1'b1, 15, base, 1'b1, 2, -1, r);
        model_xfer(1'b1, 15, base, 2 - LAT);
        n_checks++;
        if (r.act_after_abort !== 1'b0) begin n_errors++; $display("FAIL abort_quiet got %b want 0", r.act_after_abort); end
        n_checks++;
        if (r.done_cyc != -1 || r.i_wr_cnt != 0) begin
            n_errors++; $display("FAIL abort_no_done got done=%0d iwr=%0d want -1 0", r.done_cyc, r.i_wr_cnt);
        end
        n_checks++;
        if (reg_diff() != 0) begin n_errors++; $display("FAIL abort_regs got %0d bad want 0", reg_diff()); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy got %b want 0", busy); end
        // Random abort points in both directions.
        for (int it = 0; it < 8; it++) begin
            d = 1'($urandom);
            last = int'($urandom_range(1, 15));
            base = AW'($urandom);
            a = int'($urandom_range(0, d ? last + 1 + LAT - 1 : last + 1 - 1));
            do_xfer(d, last, base, 1'b1, a, -1, r);
            cnt = d ? a - int'(LAT) : a;
            model_xfer(d, last, base, cnt);
            n_checks++;
            if (mem_diff() != 0 || reg_diff() != 0) begin
                n_errors++; $display("FAIL abort_rand it=%0d a=%0d got mem=%0d regs=%0d bad want 0", it, a, mem_diff(), reg_diff());
            end
            n_checks++;
            if (r.act_after_abort !== 1'b0 || r.done_cyc != -1 || r.i_wr_cnt != 0) begin
                n_errors++; $display("FAIL abort_rand_quiet it=%0d got act=%b done=%0d want 0 -1", it, r.act_after_abort, r.done_cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t r;
        logic d;
        int last, act;
        logic [AW-1:0] base;
        // A second start during a transfer must be ignored.
        d = 1'($urandom);
        last = int'($urandom_range(2, 15));
        base = AW'($urandom);
        do_xfer(d, last, base, 1'b0, -1, 1, r);
        model_xfer(d, last, base, last + 1);
        n_checks++;
        if (mem_diff() != 0 || reg_diff() != 0) begin
            n_errors++; $display("FAIL restart_state got mem=%0d regs=%0d bad want 0", mem_diff(), reg_diff());
        end
        n_checks++;
        if (r.done_cyc + 1 != (d ? last + 1 + LAT + 2 : last + 3)) begin
            n_errors++; $display("FAIL restart_latency got %0d", r.done_cyc + 1);
        end
        // start together with abort in IDLE must not begin anything.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; dir = 1'b0; last_reg = 4'hF; base_addr = AW'($urandom);
        act = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            if (busy || ram_en || wr_en || done) act++;
        end
        n_checks++;
        if (act != 0 || mem_diff() != 0 || reg_diff() != 0) begin
            n_errors++; $display("FAIL start_abort_idle got act=%0d mem=%0d regs=%0d want 0", act, mem_diff(), reg_diff());
        end
    endtask

    task automatic test_reset_mid();
        res_t r;
        logic [AW-1:0] base;
        base = AW'($urandom);
        @(negedge clk);
        start = 1'b1; dir = 1'b0; last_reg = 4'd7; base_addr = base; quirk_inc_i = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, i_wr, wr_en, ram_en, ram_wr} !== 6'b0) begin
            n_errors++; $display("FAIL midrst_ctrl got %b want 000000", {busy, done, i_wr, wr_en, ram_en, ram_wr});
        end
        n_checks++;
        if ({i_new, rd_idx, wr_idx, wr_data, ram_addr, ram_in} !== 48'h0) begin
            n_errors++; $display("FAIL midrst_data got %h want 0", {i_new, rd_idx, wr_idx, wr_data, ram_addr, ram_in});
        end
        @(negedge clk); rst_n = 1'b1;
        // Only the write presented in cycle 1 completed before reset.
        model_xfer(1'b0, 7, base, 1);
        n_checks++;
        if (mem_diff() != 0) begin n_errors++; $display("FAIL midrst_mem got %0d bad want 0", mem_diff()); end
        base = AW'($urandom);
        do_xfer(1'b0, 0, base, 1'b1, -1, -1, r);
        model_xfer(1'b0, 0, base, 1);
        n_checks++;
        if (r.done_cyc + 1 != 3 || r.i_wr_cnt != 1) begin
            n_errors++; $display("FAIL midrst_restart got lat=%0d iwr=%0d want 3 1", r.done_cyc + 1, r.i_wr_cnt);
        end
        n_checks++;
        if (mem_diff() != 0) begin n_errors++; $display("FAIL midrst_restart_mem got %0d bad want 0", mem_diff()); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) exp_mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'($urandom);
        sync_env();
        test_reset();
        test_store();
        test_load();
        test_wrap();
        test_random();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
